// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light conflict monitor: fault codes,
// head indices, FSM states and lamp-group types.
package tlc_pkg;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_CONFLICT = 3'd1;
    localparam logic [2:0] FC_INVALID  = 3'd2;
    localparam logic [2:0] FC_SHORT_Y  = 3'd3;
    localparam logic [2:0] FC_SKIP_Y   = 3'd4;

    localparam logic [1:0] HD_12 = 2'd0;
    localparam logic [1:0] HD_34 = 2'd1;
    localparam logic [1:0] HD_5  = 2'd2;
    localparam logic [1:0] HD_6  = 2'd3;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_RUN     = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    typedef struct packed {
        logic r;
        logic y;
        logic g;
    } veh_t;

    typedef struct packed {
        logic r;
        logic g;
    } ped_t;

    localparam veh_t VEH_RED = 3'b100;
    localparam ped_t PED_RED = 2'b10;

endpackage

// File: rtl/tlc_head_tracker.sv
// Per-vehicle-head history: previous sampled lamp and saturating yellow run
// length, producing skipped/short yellow pulses and a malformed-head flag.
module tlc_head_tracker
    import tlc_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int CW         = 6
) (
    input  logic clk,
    input  logic reset,
    input  veh_t lamp,
    output logic skip_y,
    output logic short_y,
    output logic invalid
);

    localparam logic [CW-1:0] YSAT = '1;

    veh_t          prev_q;
    logic [CW-1:0] ycnt_q;
    logic [CW-1:0] ycnt_d;

    // ycnt_q holds the yellow run length ending at the previous sample
    always_comb begin
        ycnt_d = '0;
        if (lamp.y) begin
            ycnt_d = (ycnt_q == YSAT) ? ycnt_q : ycnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= VEH_RED;
            ycnt_q <= '0;
        end else begin
            prev_q <= lamp;
            ycnt_q <= ycnt_d;
        end
    end

    assign skip_y  = prev_q.g & lamp.r;
    assign short_y = prev_q.y & lamp.r & (ycnt_q < CW'(MIN_YELLOW));
    assign invalid = ($countones(lamp) != 1);

endmodule

// File: rtl/tlc_conflict_monitor.sv
// Independent lamp watchdog: samples all lamp lines, detects conflicts,
// malformed heads and bad yellow intervals, and latches the first fault.
module tlc_conflict_monitor
    import tlc_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int PERSIST    = 2,
    parameter int STARTUP    = 4,
    parameter int CW         = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       T12R,
    input  logic       T12Y,
    input  logic       T12G,
    input  logic       T34R,
    input  logic       T34Y,
    input  logic       T34G,
    input  logic       T5R,
    input  logic       T5G,
    input  logic       T6R,
    input  logic       T6G,
    input  logic       clear,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_head,
    output logic       force_flash,
    output logic       armed
);

    veh_t h12_q, h34_q;
    ped_t p5_q, p6_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h12_q <= VEH_RED;
            h34_q <= VEH_RED;
            p5_q  <= PED_RED;
            p6_q  <= PED_RED;
        end else begin
            h12_q <= {T12R, T12Y, T12G};
            h34_q <= {T34R, T34Y, T34G};
            p5_q  <= {T5R, T5G};
            p6_q  <= {T6R, T6G};
        end
    end

    logic skip12, short12, inv12;
    logic skip34, short34, inv34;

    tlc_head_tracker #(.MIN_YELLOW(MIN_YELLOW), .CW(CW)) u_h12 (
        .clk(clk), .reset(reset), .lamp(h12_q),
        .skip_y(skip12), .short_y(short12), .invalid(inv12)
    );

    tlc_head_tracker #(.MIN_YELLOW(MIN_YELLOW), .CW(CW)) u_h34 (
        .clk(clk), .reset(reset), .lamp(h34_q),
        .skip_y(skip34), .short_y(short34), .invalid(inv34)
    );

    logic          a12, a34, inv5, inv6;
    logic          c12_34, c12_5, c34_6;
    logic          static_any, trans_any, persist_hit, latch;
    logic [2:0]    static_code, trans_code, latch_code;
    logic [1:0]    static_head, trans_head, latch_head;
    logic [CW-1:0] pcnt_q, pcnt_d, scnt_q;
    state_t        state_q;
    logic [2:0]    code_q;
    logic [1:0]    head_q;
    logic          fault_q, armed_q;

    // Pedestrian heads only conflict with the vehicle head they cross
    always_comb begin
        a12    = h12_q.g | h12_q.y;
        a34    = h34_q.g | h34_q.y;
        c12_34 = a12 & a34;
        c12_5  = a12 & p5_q.g;
        c34_6  = a34 & p6_q.g;
        inv5   = ~(p5_q.r ^ p5_q.g);
        inv6   = ~(p6_q.r ^ p6_q.g);

        static_code = FC_NONE;
        static_head = HD_12;
        if (c12_34 | c12_5) begin
            static_code = FC_CONFLICT;
        end else if (c34_6) begin
            static_code = FC_CONFLICT;
            static_head = HD_34;
        end else if (inv12) begin
            static_code = FC_INVALID;
        end else if (inv34) begin
            static_code = FC_INVALID;
            static_head = HD_34;
        end else if (inv5) begin
            static_code = FC_INVALID;
            static_head = HD_5;
        end else if (inv6) begin
            static_code = FC_INVALID;
            static_head = HD_6;
        end
        static_any = (static_code != FC_NONE);

        trans_code = FC_NONE;
        trans_head = HD_12;
        if (skip12) begin
            trans_code = FC_SKIP_Y;
        end else if (skip34) begin
            trans_code = FC_SKIP_Y;
            trans_head = HD_34;
        end else if (short12) begin
            trans_code = FC_SHORT_Y;
        end else if (short34) begin
            trans_code = FC_SHORT_Y;
            trans_head = HD_34;
        end
        trans_any = (trans_code != FC_NONE);

        persist_hit = static_any && (pcnt_q >= CW'(PERSIST - 1));
        pcnt_d      = static_any ? pcnt_q + 1'b1 : '0;
        latch       = persist_hit | trans_any;
        latch_code  = persist_hit ? static_code : trans_code;
        latch_head  = persist_hit ? static_head : trans_head;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_STARTUP;
            scnt_q  <= '0;
            pcnt_q  <= '0;
            code_q  <= FC_NONE;
            head_q  <= HD_12;
            fault_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            case (state_q)
                ST_STARTUP: begin
                    pcnt_q <= '0;
                    if (scnt_q == CW'(STARTUP)) begin
                        state_q <= ST_RUN;
                        scnt_q  <= '0;
                        armed_q <= 1'b1;
                    end else begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (latch) begin
                        state_q <= ST_FAULT;
                        code_q  <= latch_code;
                        head_q  <= latch_head;
                        fault_q <= 1'b1;
                        armed_q <= 1'b0;
                        pcnt_q  <= '0;
                    end else begin
                        pcnt_q <= pcnt_d;
                    end
                end
                ST_FAULT: begin
                    if (clear) begin
                        state_q <= ST_STARTUP;
                        code_q  <= FC_NONE;
                        head_q  <= HD_12;
                        fault_q <= 1'b0;
                        scnt_q  <= '0;
                        pcnt_q  <= '0;
                    end
                end
                default: begin
                    state_q <= ST_STARTUP;
                end
            endcase
        end
    end

    assign fault       = fault_q;
    assign force_flash = fault_q;
    assign fault_code  = code_q;
    assign fault_head  = head_q;
    assign armed       = armed_q;

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// Bench for tlc_conflict_monitor: directed scenarios plus randomized lamp
// sequences, checked every cycle against a history-based reference model.
module tb_tlc_conflict_monitor;

    localparam int MIN_YELLOW = 3;
    localparam int PERSIST    = 2;
    localparam int STARTUP    = 4;
    localparam int CW         = 6;
    localparam int R = 0, Y = 1, G = 2;
    localparam logic [9:0] ALLRED = 10'b1001001010;

    logic       clk = 1'b0;
    logic       reset;
    logic       T12R, T12Y, T12G, T34R, T34Y, T34G, T5R, T5G, T6R, T6G;
    logic       clear;
    logic       fault, force_flash, armed;
    logic [2:0] fault_code;
    logic [1:0] fault_head;

    always #5 clk = ~clk;

    tlc_conflict_monitor #(
        .MIN_YELLOW(MIN_YELLOW), .PERSIST(PERSIST), .STARTUP(STARTUP), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .T12R(T12R), .T12Y(T12Y), .T12G(T12G),
        .T34R(T34R), .T34Y(T34Y), .T34G(T34G),
        .T5R(T5R), .T5G(T5G), .T6R(T6R), .T6G(T6G),
        .clear(clear), .fault(fault), .fault_code(fault_code),
        .fault_head(fault_head), .force_flash(force_flash), .armed(armed)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    // Lamp vector: {12R,12Y,12G, 34R,34Y,34G, 5R,5G, 6R,6G}
    function automatic logic [9:0] mk(input int h12, input int h34, input int p5, input int p6);
        logic [2:0] a, b;
        a = (h12 == R) ? 3'b100 : (h12 == Y) ? 3'b010 : 3'b001;
        b = (h34 == R) ? 3'b100 : (h34 == Y) ? 3'b010 : 3'b001;
        return {a, b, (p5 != 0) ? 2'b01 : 2'b10, (p6 != 0) ? 2'b01 : 2'b10};
    endfunction

    task automatic apply(input logic [9:0] v);
        {T12R, T12Y, T12G, T34R, T34Y, T34G, T5R, T5G, T6R, T6G} = v;
    endtask

    // Reference model: full sample history since reset, rules evaluated on it
    logic [9:0] hist[$];
    int         e, start, mcode, mhead;
    bit         mfault;

    function automatic int scode(input logic [9:0] v);
        bit g12, g34;
        g12 = v[8] | v[7];
        g34 = v[5] | v[4];
        if ((g12 && g34) || (g12 && v[2]) || (g34 && v[0])) return 1;
        if ($countones(v[9:7]) != 1 || $countones(v[6:4]) != 1) return 2;
        if (v[3] == v[2] || v[1] == v[0]) return 2;
        return 0;
    endfunction

    function automatic int shead(input logic [9:0] v);
        bit g12, g34;
        g12 = v[8] | v[7];
        g34 = v[5] | v[4];
        if ((g12 && g34) || (g12 && v[2])) return 0;
        if (g34 && v[0]) return 1;
        if ($countones(v[9:7]) != 1) return 0;
        if ($countones(v[6:4]) != 1) return 1;
        if (v[3] == v[2]) return 2;
        return 3;
    endfunction

    function automatic int yrun(input int idx, input int bitpos);
        int n = 0;
        while (idx >= 0 && hist[idx][bitpos]) begin
            n++;
            idx--;
        end
        return n;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(ALLRED);
        e = 0; start = 0; mfault = 0; mcode = 0; mhead = 0;
    endtask

    task automatic mlatch(input int c, input int h);
        mfault = 1; mcode = c; mhead = h;
    endtask

    task automatic model_step(input logic [9:0] v, input bit clr);
        int run_cnt, j;
        logic [9:0] prv, cur;
        e++;
        if (mfault) begin
            if (clr) begin
                mfault = 0; mcode = 0; mhead = 0; start = e;
            end
        end else if (e - 1 - start >= STARTUP + 1) begin
            run_cnt = 0;
            j = e - 1;
            while (j >= start + STARTUP + 1 && scode(hist[j]) != 0) begin
                run_cnt++;
                j--;
            end
            prv = hist[e-2];
            cur = hist[e-1];
            if (run_cnt >= PERSIST) mlatch(scode(cur), shead(cur));
            else if (prv[7] && cur[9]) mlatch(4, 0);
            else if (prv[4] && cur[6]) mlatch(4, 1);
            else if (prv[8] && cur[9] && yrun(e-2, 8) < MIN_YELLOW) mlatch(3, 0);
            else if (prv[5] && cur[6] && yrun(e-2, 5) < MIN_YELLOW) mlatch(3, 1);
        end
        hist.push_back(v);
    endtask

    task automatic compare();
        bit marmed;
        marmed = !mfault && (e - start >= STARTUP + 1);
        check("fault", fault, int'(mfault));
        check("fault_code", fault_code, mcode);
        check("fault_head", fault_head, mhead);
        check("force_flash", force_flash, int'(mfault));
        check("armed", armed, int'(marmed));
    endtask

    task automatic cyc(input logic [9:0] v, input bit clr);
        apply(v);
        clear = clr;
        @(posedge clk);
        model_step(v, clr);
        @(negedge clk);
        compare();
    endtask

    task automatic hold(input logic [9:0] v, input int n);
        for (int i = 0; i < n; i++) cyc(v, 1'b0);
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        check("arst_fault", fault, 0);
        check("arst_code", fault_code, 0);
        check("arst_head", fault_head, 0);
        check("arst_flash", force_flash, 0);
        check("arst_armed", armed, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic recover();
        cyc(ALLRED, 1'b1);
        hold(ALLRED, 6);
    endtask

    initial begin
        logic [9:0] v;
        int ph, rem, r;
        bit clr;

        reset = 1'b1;
        clear = 1'b0;
        apply(ALLRED);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_fault", fault, 0);
        check("rst_code", fault_code, 0);
        check("rst_flash", force_flash, 0);
        check("rst_armed", armed, 0);
        reset = 1'b0;

        // Legal cycle, then a variant with pedestrian service moved
        hold(mk(G, R, R, G), 4);
        check("t1_armed_c4", armed, 0);
        cyc(mk(G, R, R, G), 1'b0);
        check("t1_armed_c5", armed, 1);
        hold(mk(Y, R, R, G), 3);
        hold(ALLRED, 1);
        hold(mk(R, G, G, R), 4);
        hold(mk(R, Y, G, R), 3);
        hold(ALLRED, 1);
        hold(mk(G, R, R, R), 4);
        hold(mk(Y, R, R, R), 3);
        hold(mk(R, R, G, G), 2);
        hold(mk(R, G, R, R), 4);
        hold(mk(R, Y, R, R), 3);
        hold(mk(R, R, G, G), 2);
        check("t1_nofault", fault, 0);

        // Conflict: one-cycle glitch is filtered, two sampled cycles latch
        hold(mk(G, R, R, G), 2);
        cyc(mk(G, R, G, G), 1'b0);
        hold(mk(G, R, R, G), 3);
        check("t2_glitch", fault, 0);
        hold(mk(G, G, R, R), 2);
        check("t2_before", fault, 0);
        cyc(mk(G, G, R, R), 1'b0);
        check("t2_fault", fault, 1);
        check("t2_code", fault_code, 1);
        check("t2_head", fault_head, 0);
        hold(ALLRED, 2);
        recover();

        // Short yellow on head 34, then a full-length yellow
        hold(mk(R, G, G, R), 3);
        hold(mk(R, Y, G, R), 2);
        cyc(ALLRED, 1'b0);
        check("t3_before", fault, 0);
        cyc(ALLRED, 1'b0);
        check("t3_code", fault_code, 3);
        check("t3_head", fault_head, 1);
        recover();
        hold(mk(R, G, G, R), 3);
        hold(mk(R, Y, G, R), 3);
        hold(ALLRED, 3);
        check("t3_longy", fault, 0);

        // Conflict outranks the skipped yellow that follows it
        hold(mk(G, R, R, R), 3);
        hold(mk(G, R, G, R), 2);
        check("t4_before", fault, 0);
        cyc(ALLRED, 1'b0);
        check("t4_conf_code", fault_code, 1);
        hold(ALLRED, 1);
        recover();
        hold(mk(G, R, R, R), 3);
        cyc(ALLRED, 1'b0);
        check("t4_skip_before", fault, 0);
        cyc(ALLRED, 1'b0);
        check("t4_skip_code", fault_code, 4);
        check("t4_skip_head", fault_head, 0);

        // Clear restarts the startup window; reset acts mid-fault at once
        cyc(ALLRED, 1'b1);
        check("t5_clr_fault", fault, 0);
        hold(ALLRED, 4);
        check("t5_armed_low", armed, 0);
        cyc(ALLRED, 1'b0);
        check("t5_armed_high", armed, 1);
        hold(mk(G, R, R, R), 3);
        hold(ALLRED, 2);
        check("t5_refault", fault, 1);
        async_reset();

        // Randomized controller-like traffic with corruption and clears
        ph = 5;
        rem = 0;
        for (int i = 0; i < 1500; i++) begin
            if (rem == 0) begin
                ph = (ph + 1) % 6;
                if ((ph == 1 || ph == 4) && $urandom_range(0, 9) == 0) ph++;
                rem = (ph == 0 || ph == 3) ? $urandom_range(2, 6) :
                      (ph == 1 || ph == 4) ? $urandom_range(1, 4) : $urandom_range(1, 2);
            end
            case (ph)
                0:       v = mk(G, R, R, G);
                1:       v = mk(Y, R, R, G);
                3:       v = mk(R, G, G, R);
                4:       v = mk(R, Y, G, R);
                default: v = mk(R, R, $urandom_range(0, 1), $urandom_range(0, 1));
            endcase
            rem--;
            r = $urandom_range(0, 99);
            if (r < 3) v = 10'($urandom);
            else if (r < 6) v[$urandom_range(0, 9)] = ~v[$urandom_range(0, 9)];
            clr = mfault ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
            cyc(v, clr);
            if ($urandom_range(0, 399) == 0) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
